// File: rtl/bm_mem_ctrl_pkg.sv
// bm_mem_ctrl_pkg: shared constants and types for the bitmatrix column memory.
//   - default geometry (column width, depth, address width, read latency)
//   - controller state enum
//   - bit positions inside the sticky error vector {addr_err, rd_err, wr_err}
package bm_mem_ctrl_pkg;

  localparam int unsigned BM_COL_W      = 256;
  localparam int unsigned BM_MEM_DEPTH  = 64;
  localparam int unsigned BM_MEM_ADDR_W = 6;
  localparam int unsigned BM_RD_LAT     = 2;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } bm_mem_state_t;

  localparam int unsigned ERR_WR   = 0;
  localparam int unsigned ERR_RD   = 1;
  localparam int unsigned ERR_ADDR = 2;

endpackage

// File: rtl/bm_mem_ctrl_if.sv
// bm_mem_ctrl_if: host load port plus bm_cntl read port of the column memory.
//   master : host / bm_cntl side (drives load, write and read-request signals)
//   slave  : bm_mem_ctrl side (returns read data, valid, ready, wr_cnt, errors)
interface bm_mem_ctrl_if
  import bm_mem_ctrl_pkg::*;
#(
  parameter int unsigned COL_W  = BM_COL_W,
  parameter int unsigned ADDR_W = BM_MEM_ADDR_W
);

  logic              host_bm_load_start;
  logic              host_bm_mem_wr_en;
  logic [ADDR_W-1:0] host_bm_mem_wr_addr;
  logic [COL_W-1:0]  host_bm_mem_wr_data;
  logic              host_bm_load_done;
  logic              host_bm_clr;
  logic              bm_cntl_bm_mem_rd_rq;
  logic [ADDR_W-1:0] bm_cntl_bm_mem_rd_addr;
  logic [COL_W-1:0]  bm_mem_bm_cntl_rd_data;
  logic              bm_mem_bm_cntl_rd_data_val;
  logic              bm_mem_ready;
  logic [ADDR_W:0]   bm_mem_wr_cnt;
  logic [2:0]        bm_mem_err;

  modport master (
    output host_bm_load_start, host_bm_mem_wr_en, host_bm_mem_wr_addr,
           host_bm_mem_wr_data, host_bm_load_done, host_bm_clr,
           bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
    input  bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
           bm_mem_ready, bm_mem_wr_cnt, bm_mem_err
  );

  modport slave (
    input  host_bm_load_start, host_bm_mem_wr_en, host_bm_mem_wr_addr,
           host_bm_mem_wr_data, host_bm_load_done, host_bm_clr,
           bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
    output bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
           bm_mem_ready, bm_mem_wr_cnt, bm_mem_err
  );

endinterface

// File: rtl/bm_mem_ctrl_array.sv
// bm_mem_ctrl_array: 1R1W column storage, MEM_DEPTH x COL_W, registered read.
//   clk, rstn  : clock, synchronous active-low reset (read register only)
//   wr_en_i    : write strobe, wr_idx_i / wr_data_i
//   rd_en_i    : load the read register this cycle from rd_idx_i
//   rd_zero_i  : with rd_en_i, load zero instead of array contents
//   rd_data_o  : read register, holds its value while rd_en_i is low
module bm_mem_ctrl_array #(
  parameter int unsigned COL_W     = 256,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [COL_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_zero_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [COL_W-1:0] rd_data_o
);

  logic [COL_W-1:0] mem_q [MEM_DEPTH];
  logic [COL_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= rd_zero_i ? '0 : mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/bm_mem_ctrl.sv
// bm_mem_ctrl: bitmatrix column memory and access controller.
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : slave side of bm_mem_ctrl_if (host load/lock/clear, bm_cntl reads,
//          read data + valid pulse, ready, accepted write count, sticky errors)
// Host loads columns in LOADING, locks with load_done (READY); reads are only
// served in READY and return after RD_LAT cycles with a one-cycle valid.
module bm_mem_ctrl
  import bm_mem_ctrl_pkg::*;
#(
  parameter int unsigned COL_W     = BM_COL_W,
  parameter int unsigned MEM_DEPTH = BM_MEM_DEPTH,
  parameter int unsigned ADDR_W    = BM_MEM_ADDR_W,
  parameter int unsigned RD_LAT    = BM_RD_LAT
) (
  input logic         clk,
  input logic         rstn,
  bm_mem_ctrl_if.slave bus
);

  localparam int unsigned      IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  bm_mem_state_t    state_q;
  logic             ready_q;
  logic [ADDR_W:0]  wr_cnt_q;
  logic [2:0]       err_q;
  logic [RD_LAT-1:0] val_q;

  logic             clr;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             wr_bad;
  logic             rd_acc;
  logic             rd_bad_addr;
  logic             rd_bad_state;
  logic [COL_W-1:0] arr_rd;
  logic [COL_W-1:0] rd_data;

  // clr outranks every other input: it also suppresses writes and reads in its cycle
  always_comb begin
    clr          = bus.host_bm_clr;
    wr_in_range  = {1'b0, bus.host_bm_mem_wr_addr} < DEPTH_C;
    rd_in_range  = {1'b0, bus.bm_cntl_bm_mem_rd_addr} < DEPTH_C;
    wr_ok        = !clr && bus.host_bm_mem_wr_en && (state_q == LOADING) && wr_in_range;
    wr_bad       = !clr && bus.host_bm_mem_wr_en && !((state_q == LOADING) && wr_in_range);
    // out-of-range reads in READY still return a (zero) response
    rd_acc       = !clr && bus.bm_cntl_bm_mem_rd_rq && (state_q == READY);
    rd_bad_addr  = rd_acc && !rd_in_range;
    rd_bad_state = !clr && bus.bm_cntl_bm_mem_rd_rq && (state_q != READY);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= EMPTY;
      ready_q  <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= '0;
    end else if (clr) begin
      state_q  <= EMPTY;
      ready_q  <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      if (wr_bad)       err_q[ERR_WR]   <= 1'b1;
      if (rd_bad_state) err_q[ERR_RD]   <= 1'b1;
      if (rd_bad_addr)  err_q[ERR_ADDR] <= 1'b1;
      if (wr_ok && (wr_cnt_q < DEPTH_C)) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (bus.host_bm_load_start) begin
            state_q  <= LOADING;
            wr_cnt_q <= '0;
          end
        end
        LOADING: begin
          // a write coinciding with load_done is counted above; load_start wins over load_done
          if (bus.host_bm_load_done && !bus.host_bm_load_start) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.host_bm_load_start) begin
            state_q  <= LOADING;
            ready_q  <= 1'b0;
            wr_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  bm_mem_ctrl_array #(
    .COL_W     (COL_W),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (wr_ok),
    .wr_idx_i  (bus.host_bm_mem_wr_addr[IDX_W-1:0]),
    .wr_data_i (bus.host_bm_mem_wr_data),
    .rd_en_i   (rd_acc),
    .rd_zero_i (!rd_in_range),
    .rd_idx_i  (bus.bm_cntl_bm_mem_rd_addr[IDX_W-1:0]),
    .rd_data_o (arr_rd)
  );

  // valid shift register; not touched by clr so in-flight reads complete
  always_ff @(posedge clk) begin
    if (!rstn) begin
      val_q <= '0;
    end else begin
      val_q <= (val_q << 1) | RD_LAT'(rd_acc);
    end
  end

  // Array read register is stage 1. Intermediate stages shift freely; only the
  // last stage is gated by its valid so rd_data holds between responses.
  if (RD_LAT == 1) begin : g_lat1
    assign rd_data = arr_rd;
  end else begin : g_latn
    logic [COL_W-1:0] src;
    logic [COL_W-1:0] out_q;

    if (RD_LAT == 2) begin : g_direct
      assign src = arr_rd;
    end else begin : g_pipe
      localparam int unsigned PW = (RD_LAT - 2) * COL_W;
      logic [PW-1:0] pipe_q;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= (pipe_q << COL_W) | PW'(arr_rd);
        end
      end

      assign src = pipe_q[PW-1 -: COL_W];
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        out_q <= '0;
      end else if (val_q[RD_LAT-2]) begin
        out_q <= src;
      end
    end

    assign rd_data = out_q;
  end

  assign bus.bm_mem_bm_cntl_rd_data     = rd_data;
  assign bus.bm_mem_bm_cntl_rd_data_val = val_q[RD_LAT-1];
  assign bus.bm_mem_ready               = ready_q;
  assign bus.bm_mem_wr_cnt              = wr_cnt_q;
  assign bus.bm_mem_err                 = err_q;

endmodule

// File: tb/tb_bm_mem_ctrl.sv
// tb_bm_mem_ctrl: directed scenarios plus random traffic for bm_mem_ctrl,
// checked by a scoreboard fed from a behavioural model of the memory.
module tb_bm_mem_ctrl;

  localparam int unsigned COL_W = 256;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 7;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bm_mem_ctrl_if #(.COL_W(COL_W), .ADDR_W(AW)) bus ();

  bm_mem_ctrl #(
    .COL_W     (COL_W),
    .MEM_DEPTH (DEPTH),
    .ADDR_W    (AW),
    .RD_LAT    (LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [COL_W-1:0] data;
    bit               dc;
    time              due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 0;

  // behavioural model
  logic [COL_W-1:0] m_mem [DEPTH];
  bit               m_vld [DEPTH];
  bit               m_loading, m_locked;
  int unsigned      m_cnt;
  logic [2:0]       m_err;
  logic [COL_W-1:0] m_last;

  task automatic chk(input string name, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not matching expectation at %0t", name, $time);
  endtask

  task automatic model_apply(input bit rst_n, input bit clr, input bit ls, input bit ld,
                             input bit we, input int unsigned wa, input logic [COL_W-1:0] wd,
                             input bit rq, input int unsigned ra);
    exp_t e;
    if (!rst_n) begin
      m_loading = 0; m_locked = 0; m_cnt = 0; m_err = '0; m_last = '0;
      sb_q.delete();
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    end else if (clr) begin
      m_loading = 0; m_locked = 0; m_cnt = 0; m_err = '0;
    end else begin
      if (we) begin
        if (m_loading && wa < DEPTH) begin
          m_mem[wa] = wd;
          m_vld[wa] = 1;
          if (m_cnt < DEPTH) m_cnt++;
        end else begin
          m_err[0] = 1'b1;
        end
      end
      if (rq) begin
        if (m_locked) begin
          e.due = $time + (LAT - 1) * 10 + 5;
          if (ra < DEPTH) begin
            e.data = m_mem[ra];
            e.dc   = !m_vld[ra];
          end else begin
            e.data = '0;
            e.dc   = 0;
            m_err[2] = 1'b1;
          end
          sb_q.push_back(e);
        end else begin
          m_err[1] = 1'b1;
        end
      end
      if (ls && !m_loading) begin
        m_loading = 1; m_locked = 0; m_cnt = 0;
      end else if (ld && m_loading && !ls) begin
        m_loading = 0; m_locked = 1;
      end
    end
  endtask

  task automatic cyc(input bit rst_n, input bit clr, input bit ls, input bit ld,
                     input bit we, input int unsigned wa, input logic [COL_W-1:0] wd,
                     input bit rq, input int unsigned ra);
    rstn                       = rst_n;
    bus.host_bm_clr            = clr;
    bus.host_bm_load_start     = ls;
    bus.host_bm_load_done      = ld;
    bus.host_bm_mem_wr_en      = we;
    bus.host_bm_mem_wr_addr    = AW'(wa);
    bus.host_bm_mem_wr_data    = wd;
    bus.bm_cntl_bm_mem_rd_rq   = rq;
    bus.bm_cntl_bm_mem_rd_addr = AW'(ra);
    @(posedge clk);
    model_apply(rst_n, clr, ls, ld, we, wa, wd, rq, ra);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) cyc(1, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask
  task automatic wr(input int unsigned a, input logic [COL_W-1:0] d);
    cyc(1, 0, 0, 0, 1, a, d, 0, 0);
  endtask
  task automatic rd(input int unsigned a);
    cyc(1, 0, 0, 0, 0, 0, '0, 1, a);
  endtask
  task automatic load_start();
    cyc(1, 0, 1, 0, 0, 0, '0, 0, 0);
  endtask
  task automatic load_done();
    cyc(1, 0, 0, 1, 0, 0, '0, 0, 0);
  endtask
  task automatic clear();
    cyc(1, 1, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic expect_status(input string tag, input bit rdy, input int unsigned cnt, input logic [2:0] err);
    chk({tag, "_ready"},  COL_W'(bus.bm_mem_ready),  COL_W'(rdy));
    chk({tag, "_wr_cnt"}, COL_W'(bus.bm_mem_wr_cnt), COL_W'(cnt));
    chk({tag, "_err"},    COL_W'(bus.bm_mem_err),    COL_W'(err));
  endtask

  // monitor: pops the scoreboard on every valid, checks hold and status otherwise
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due < $time) begin
        fail_evt("rd_val_missing");
        void'(sb_q.pop_front());
      end
      if (bus.bm_mem_bm_cntl_rd_data_val === 1'b1) begin
        if (sb_q.size() == 0) begin
          fail_evt("rd_val_unexpected");
        end else begin
          e = sb_q.pop_front();
          chk("rd_time", COL_W'($time), COL_W'(e.due));
          if (!e.dc) chk("rd_data", bus.bm_mem_bm_cntl_rd_data, e.data);
          m_last = e.dc ? bus.bm_mem_bm_cntl_rd_data : e.data;
        end
      end else begin
        chk("rd_val_low", COL_W'(bus.bm_mem_bm_cntl_rd_data_val), '0);
        chk("rd_hold", bus.bm_mem_bm_cntl_rd_data, m_last);
      end
      chk("ready",  COL_W'(bus.bm_mem_ready),  COL_W'(m_locked));
      chk("wr_cnt", COL_W'(bus.bm_mem_wr_cnt), COL_W'(m_cnt));
      chk("err",    COL_W'(bus.bm_mem_err),    COL_W'(m_err));
    end
  end

  initial begin
    // 1: reset, load four columns, lock
    cyc(0, 0, 0, 0, 0, 0, '0, 0, 0);
    mon_en = 1;
    cyc(0, 0, 0, 0, 0, 0, '0, 0, 0);
    expect_status("reset", 0, 0, 3'b000);
    chk("reset_val",  COL_W'(bus.bm_mem_bm_cntl_rd_data_val), '0);
    chk("reset_data", bus.bm_mem_bm_cntl_rd_data, '0);
    load_start();
    for (int i = 0; i < 4; i++) wr(i, COL_W'(32'hA0 + i));
    load_done();
    expect_status("t1", 1, 4, 3'b000);

    // 2: back-to-back reads
    for (int i = 0; i < 4; i++) rd(i);
    idle(4);

    // 3: read while loading, then out-of-range read while ready
    load_start();
    rd(5);
    expect_status("t3_rd_loading", 0, 0, 3'b010);
    load_done();
    rd(64);
    idle(3);
    expect_status("t3_rd_addr", 1, 0, 3'b110);

    // 4: write while ready is rejected, then clear
    wr(0, COL_W'(32'hFF));
    rd(0);
    idle(3);
    expect_status("t4_wr_ready", 1, 0, 3'b111);
    clear();
    expect_status("t4_clr", 0, 0, 3'b000);

    // 5: read in flight across clr, then read in EMPTY
    load_start();
    load_done();
    rd(1);
    clear();
    idle(3);
    rd(2);
    idle(3);
    expect_status("t5_rd_empty", 0, 0, 3'b010);

    // 6: reset kills in-flight read; reload with write + load_done together
    clear();
    load_start();
    load_done();
    rd(3);
    cyc(0, 0, 0, 0, 0, 0, '0, 0, 0);
    chk("t6_rst_val",  COL_W'(bus.bm_mem_bm_cntl_rd_data_val), '0);
    chk("t6_rst_data", bus.bm_mem_bm_cntl_rd_data, '0);
    expect_status("t6_rst", 0, 0, 3'b000);
    idle(3);
    load_start();
    wr(0, COL_W'(32'hC0));
    wr(1, COL_W'(32'hC1));
    cyc(1, 0, 0, 1, 1, 2, COL_W'(32'hC2), 0, 0);
    expect_status("t6_reload", 1, 3, 3'b000);
    rd(2);
    idle(3);

    // 7: write count saturates; write to addr == DEPTH is rejected
    load_start();
    for (int i = 0; i < DEPTH + 2; i++) wr(i % DEPTH, {8{$urandom}});
    wr(DEPTH, COL_W'(32'hDEAD));
    load_done();
    expect_status("t7_sat", 1, DEPTH, 3'b001);
    rd(DEPTH - 1);
    rd(0);
    idle(3);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 11) == 0),
          $urandom_range(0, 1) == 1, $urandom_range(0, 70), {8{$urandom}},
          $urandom_range(0, 1) == 1, $urandom_range(0, 70));
    end
    idle(6);
    chk("sb_drained", COL_W'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
